// File: rtl/req_gnt_pkg.sv
// Shared types and helpers for the req/gnt request-side master.
// Round-robin pick is written for up to 16 clients; narrower request vectors are zero-padded.
package req_gnt_pkg;

  localparam int unsigned DEF_NUM_CLIENTS = 4;
  localparam int unsigned DEF_TIMEOUT     = 16;
  localparam int unsigned MAX_CLIENTS     = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GNT_WAIT,
    COOL
  } req_gnt_state_e;

  // Zero padding above NUM_CLIENTS makes the mod-16 wrap equivalent to a mod-NUM_CLIENTS wrap.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
    logic [3:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/req_gnt_master_rr_arbiter.sv
// Round-robin arbiter: combinational winner from the live request vector,
// pointer advanced past the finishing client on each ack/nack strobe.
module rr_arbiter
  import req_gnt_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
  localparam int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic                   upd_i,
  input  logic [IDX_W-1:0]       upd_idx_i,
  output logic [NUM_CLIENTS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]       gnt_idx_o,
  output logic                   any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       pick;

  always_comb begin
    pick      = rr_pick(16'(req_i), 4'(ptr_q));
    any_o     = |req_i;
    gnt_idx_o = IDX_W'(pick);
    gnt_oh_o  = any_o ? (NUM_CLIENTS'(1) << gnt_idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (upd_idx_i == IDX_W'(NUM_CLIENTS - 1)) ? '0 : upd_idx_i + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/req_gnt_master.sv
// Request-side bus master: arbitrates local clients, issues one-cycle req pulses,
// returns ack/nack per client and flags grant-side protocol deviations.
module req_gnt_master
  import req_gnt_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter  int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter  int unsigned CNT_W       = 16,
  localparam int unsigned IDX_W       = $clog2(NUM_CLIENTS),
  localparam int unsigned WAIT_W      = $clog2(TIMEOUT)
) (
  input  logic                   clk_ip,
  input  logic                   reset_n_ip,
  input  logic [NUM_CLIENTS-1:0] client_req_i,
  output logic [NUM_CLIENTS-1:0] client_ack_o,
  output logic [NUM_CLIENTS-1:0] client_nack_o,
  output logic                   req_ip,
  input  logic                   gnt_ip,
  output logic [IDX_W-1:0]       grant_id_o,
  output logic                   busy_o,
  output logic                   late_gnt_o,
  output logic                   timeout_err_o,
  output logic                   spurious_gnt_o,
  input  logic                   clr_err_i,
  output logic [CNT_W-1:0]       done_cnt_o
);

  req_gnt_state_e state_q, state_d;

  logic                   req_q, req_d;
  logic [NUM_CLIENTS-1:0] ack_q, ack_d;
  logic [NUM_CLIENTS-1:0] nack_q, nack_d;
  logic [IDX_W-1:0]       gid_q, gid_d;
  logic [NUM_CLIENTS-1:0] goh_q, goh_d;
  logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
  logic                   late_q, late_d;
  logic                   tmo_q, tmo_d;
  logic                   spur_q, spur_d;
  logic [CNT_W-1:0]       done_q, done_d;

  logic [NUM_CLIENTS-1:0] arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   in_wait, grant_ok, tmo_hit, arb_ok;

  always_comb begin
    in_wait  = (state_q == GNT_WAIT);
    grant_ok = in_wait & gnt_ip;
    // Nack registers on the same edge the counter reaches TIMEOUT-1, TIMEOUT cycles after req.
    tmo_hit  = in_wait & ~gnt_ip & (wcnt_q == WAIT_W'(TIMEOUT - 2));
    arb_ok   = ((state_q == IDLE) || (state_q == COOL)) && arb_any;
  end

  // Pointer moves on the decision cycle so that COOL already arbitrates with the new pointer.
  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_arb (
    .clk_i    (clk_ip),
    .rst_ni   (reset_n_ip),
    .req_i    (client_req_i),
    .upd_i    (grant_ok | tmo_hit),
    .upd_idx_i(gid_q),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx),
    .any_o    (arb_any)
  );

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= '0;
      nack_q  <= '0;
      gid_q   <= '0;
      goh_q   <= '0;
      wcnt_q  <= '0;
      late_q  <= 1'b0;
      tmo_q   <= 1'b0;
      spur_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      gid_q   <= gid_d;
      goh_q   <= goh_d;
      wcnt_q  <= wcnt_d;
      late_q  <= late_d;
      tmo_q   <= tmo_d;
      spur_q  <= spur_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (arb_any) state_d = REQ;
      REQ:      state_d = GNT_WAIT;
      GNT_WAIT: if (grant_ok || tmo_hit) state_d = COOL;
      COOL:     state_d = arb_any ? REQ : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = (state_d == REQ);
    gid_d  = arb_ok ? arb_idx : gid_q;
    goh_d  = arb_ok ? arb_oh : goh_q;
    wcnt_d = wcnt_q;
    if (state_q == REQ)           wcnt_d = '0;
    else if (in_wait && !gnt_ip)  wcnt_d = wcnt_q + WAIT_W'(1);
    ack_d  = grant_ok ? goh_q : '0;
    nack_d = tmo_hit ? goh_q : '0;
    done_d = done_q + (grant_ok ? CNT_W'(1) : CNT_W'(0));
    late_d = (grant_ok && (wcnt_q != '0)) | (late_q & ~clr_err_i);
    tmo_d  = tmo_hit | (tmo_q & ~clr_err_i);
    spur_d = (gnt_ip & ~in_wait) | (spur_q & ~clr_err_i);
  end

  always_comb begin
    req_ip         = req_q;
    busy_o         = (state_q != IDLE);
    client_ack_o   = ack_q;
    client_nack_o  = nack_q;
    grant_id_o     = gid_q;
    late_gnt_o     = late_q;
    timeout_err_o  = tmo_q;
    spurious_gnt_o = spur_q;
    done_cnt_o     = done_q;
  end

endmodule

// File: tb/tb_req_gnt_master.sv
// Scoreboard bench for req_gnt_master: expected ack/nack events are queued when
// the bus grant (or its absence) is driven, and popped when the DUT pulses them.
module tb_req_gnt_master;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  creq = '0;
  logic [N-1:0]  ack, nack;
  logic          req_w;
  logic          gnt = 1'b0;
  logic [1:0]    gid;
  logic          busy, late, tmo, spur;
  logic          clr = 1'b0;
  logic [CW-1:0] done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;
  int unsigned last_evt_cyc = 0;
  int unsigned exp_q[$];
  int unsigned mon_obs;

  req_gnt_master #(
    .NUM_CLIENTS(N),
    .TIMEOUT    (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk_ip        (clk),
    .reset_n_ip    (rst_n),
    .client_req_i  (creq),
    .client_ack_o  (ack),
    .client_nack_o (nack),
    .req_ip        (req_w),
    .gnt_ip        (gnt),
    .grant_id_o    (gid),
    .busy_o        (busy),
    .late_gnt_o    (late),
    .timeout_err_o (tmo),
    .spurious_gnt_o(spur),
    .clr_err_i     (clr),
    .done_cnt_o    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Event code: client index for an ack, 256+index for a nack, 999 if not a single one-hot pulse.
  function automatic int unsigned evt_code(input logic [N-1:0] a, input logic [N-1:0] n);
    int unsigned base;
    logic [N-1:0] v;
    if ($onehot(a) && n == '0) begin base = 0;   v = a; end
    else if ($onehot(n) && a == '0) begin base = 256; v = n; end
    else return 999;
    for (int unsigned i = 0; i < N; i++) if (v[i]) return base + i;
    return 999;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ((ack | nack) != '0)) begin
      mon_obs      = evt_code(ack, nack);
      last_evt_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_evt", mon_obs, 32'hFFFF);
      else                   check("evt", mon_obs, exp_q.pop_front());
    end
  end

  task automatic wait_req(output int unsigned c);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_w === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check("req_wait_timeout", 0, 1);
    c = cyc;
  endtask

  // Grant arrives `delay` cycles after the nominal slot (cycle after req).
  task automatic serve(input int unsigned exp_id, input int unsigned delay, input bit drop,
                       output int unsigned c);
    wait_req(c);
    check("grant_id", gid, exp_id);
    exp_q.push_back(exp_id);
    repeat (delay) @(posedge clk);
    @(posedge clk); #1 gnt = 1'b1;
    @(posedge clk); #1 gnt = 1'b0;
    if (drop) creq = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int unsigned c, prev;
    int unsigned order[5] = '{0, 1, 2, 3, 0};

    #12;
    check("rst_req", req_w, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", gid, 0);
    check("rst_flags", {late, tmo, spur}, 0);
    check("rst_done", done, 0);
    check("rst_acknack", {ack, nack}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single client, immediate grant
    @(negedge clk); creq = 4'b0001;
    wait_req(c);
    check("t1_gid", gid, 0);
    exp_q.push_back(0);
    @(posedge clk); #1 gnt = 1'b1;
    @(negedge clk); check("t1_req_n1", req_w, 0);
    @(posedge clk); #1 gnt = 1'b0; creq = '0;
    @(negedge clk);
    check("t1_req_n2", req_w, 0);
    check("t1_ack", ack, 4'b0001);
    check("t1_done", done, 1);
    check("t1_flags", {late, tmo, spur}, 0);

    // All clients held, immediate grants: rotation and 3-cycle spacing
    do_reset();
    check("t2_done_rst", done, 0);
    creq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(order[k], 0, (k == 4), c);
      if (k > 0) check("t2_spacing", c - prev, 3);
      prev = c;
    end
    @(negedge clk); @(negedge clk);
    check("t2_done", done, 5);

    // Late grant (2 cycles delayed), then clear
    creq = 4'b0100;
    serve(2, 2, 1, c);
    @(negedge clk);
    check("t3_late", late, 1);
    check("t3_tmo", tmo, 0);
    check("t3_done", done, 6);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("t3_late_clr", late, 0);

    // No grant: nack TIMEOUT cycles after req
    @(negedge clk); creq = 4'b1000;
    wait_req(c);
    check("t4_gid", gid, 3);
    exp_q.push_back(256 + 3);
    repeat (TMO) @(posedge clk);
    #1 creq = '0;
    @(negedge clk); @(negedge clk);
    check("t4_nack_lat", last_evt_cyc - c, TMO);
    check("t4_tmo", tmo, 1);
    check("t4_done", done, 6);
    creq = 4'b1111;
    serve(0, 0, 1, c);
    @(negedge clk); @(negedge clk);
    check("t4_done2", done, 7);

    // Spurious grant in IDLE
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    check("t5_spur", spur, 1);
    check("t5_busy", busy, 0);
    @(negedge clk);
    check("t5_req", req_w, 0);
    check("t5_busy2", busy, 0);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("t5_clr", {late, tmo, spur}, 0);

    // Reset during GNT_WAIT
    creq = 4'b0010;
    wait_req(c);
    check("t6_gid", gid, 1);
    @(posedge clk); #2;
    check("t6_busy_wait", busy, 1);
    rst_n = 1'b0; #1;
    check("t6_req", req_w, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    creq = 4'b1111;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    serve(0, 0, 1, c);
    repeat (4) @(negedge clk);
    check("t6_done2", done, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/req_gnt_master.md
# req_gnt_master

Upstream request-side master for the single-bit req/gnt handshake. Arbitrates round-robin among `NUM_CLIENTS` local clients and issues one-cycle `req_ip` pulses on the bus. Consumes `gnt_ip` and returns per-client ack/nack. Drives the bus so that every request satisfies `req_ip |=> (~req_ip & gnt_ip) ##1 (~req_ip & ~gnt_ip)`, and flags any grant-side deviation.

## Interface
- `NUM_CLIENTS`, default 4: number of local requesters, 2..16.
- `TIMEOUT`, default 16: cycles waited in GNT_WAIT before abort, ≥2.
- `CNT_W`, default 16: width of the completed-transaction counter.
- `clk_ip` in 1: single clock; all logic on its rising edge.
- `reset_n_ip` in 1: reset, asynchronous and active-low.
- `client_req_i` in NUM_CLIENTS: level request; held until ack or nack.
- `client_ack_o` out NUM_CLIENTS: one-hot, 1-cycle pulse on successful grant.
- `client_nack_o` out NUM_CLIENTS: one-hot, 1-cycle pulse on timeout abort.
- `req_ip` out 1: registered bus request pulse.
- `gnt_ip` in 1: bus grant.
- `grant_id_o` out $clog2(NUM_CLIENTS): client owning the current or last transaction.
- `busy_o` out 1: high in REQ, GNT_WAIT, COOL.
- `late_gnt_o` out 1: sticky; grant arrived later than the cycle after `req_ip`.
- `timeout_err_o` out 1: sticky; transaction aborted.
- `spurious_gnt_o` out 1: sticky; `gnt_ip` high outside GNT_WAIT.
- `clr_err_i` in 1: synchronous clear of the three sticky flags.
- `done_cnt_o` out CNT_W: completed grants; wraps modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: if any `client_req_i` bit is set, latch the arbiter winner into `grant_id_o` and go to REQ.
  - REQ: `req_ip` = 1 for exactly this cycle. Go to GNT_WAIT. Clear the wait counter.
  - GNT_WAIT: `req_ip` = 0.
    - `gnt_ip` = 1: pulse `client_ack_o[grant_id]`, increment `done_cnt_o`, go to COOL. Set `late_gnt_o` if the wait counter ≠ 0.
    - `gnt_ip` = 0: increment the wait counter. When the counter reaches TIMEOUT−1, pulse `client_nack_o[grant_id]`, set `timeout_err_o`, go to COOL.
  - COOL: `req_ip` = 0 for one cycle. Then go to REQ if any request is pending (winner latched as in IDLE), else to IDLE.
- Arbitration:
  - Winner is the lowest set index at or above `rr_ptr`, wrapping to 0.
  - On every ack or nack, `rr_ptr` ← `grant_id` + 1, modulo NUM_CLIENTS.
  - A client's request is considered only while its `client_req_i` is high at arbitration time. A deassert during REQ/GNT_WAIT does not cancel the transaction.
- `spurious_gnt_o` is set when `gnt_ip` = 1 in IDLE, REQ or COOL. The FSM ignores such grants.
- `clr_err_i` coincident with a set condition: the set wins.
- `done_cnt_o` wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset values: state IDLE; `req_ip` 0; ack/nack 0; `grant_id_o` 0; `rr_ptr` 0; `busy_o` 0; all sticky flags 0; `done_cnt_o` 0.
- Reset assertion forces `req_ip` low asynchronously, mid-transaction included. No ack/nack is issued for the aborted transaction.
- Request latency: `client_req_i` high at edge t in IDLE gives `req_ip` high in cycle t+1.
- Nominal handshake: `req_ip` in cycle n, `gnt_ip` in n+1, `client_ack_o` pulse in n+1 (registered, visible from edge n+2). `req_ip` stays low in n+1 and n+2.
- Next `req_ip` no earlier than n+3, giving a minimum pulse spacing of 3 cycles.
- Timeout: with no grant, nack is issued TIMEOUT cycles after `req_ip`.

## Structure
- Package `req_gnt_pkg`:
  - state enum `req_gnt_state_e` {IDLE, REQ, GNT_WAIT, COOL};
  - localparam defaults for NUM_CLIENTS and TIMEOUT;
  - function `rr_pick(req, ptr)`.
- Sub-module `rr_arbiter`: combinational request vector plus registered pointer, giving a one-hot winner and its index. Pointer update is strobed by ack|nack.
- Top level holds the FSM, wait counter, sticky flags and `done_cnt_o`.

## Test plan
- Single client: `client_req_i` = 4'b0001; `gnt_ip` one cycle after `req_ip` → `client_ack_o` = 4'b0001; `done_cnt_o` = 1; no flags; `req_ip` low for the 2 following cycles.
- All four clients held high, immediate grants → ack order 0, 1, 2, 3, 0; `req_ip` pulses exactly 3 cycles apart.
- Grant delayed 2 cycles → ack to the owner; `late_gnt_o` = 1; `clr_err_i` pulse → `late_gnt_o` = 0.
- No grant, TIMEOUT = 16 → `client_nack_o` pulses 16 cycles after `req_ip`; `timeout_err_o` = 1; `done_cnt_o` unchanged; `rr_ptr` advances.
- `gnt_ip` high while IDLE → `spurious_gnt_o` = 1; no ack; state remains IDLE.
- `reset_n_ip` low during GNT_WAIT → `req_ip` = 0, `busy_o` = 0, counter 0 immediately; after release, a held request restarts from client 0.
